router_fsm_ctrl_n: RTL
======================

Name: router_fsm_ctrl_n

Overview:
- Parametrised successor to the 1x3 router FSM controller: one FSM serves NUM_PORTS destination FIFOs instead of a fixed three.
- The block sits between the router's input register/parity block and the synchroniser/FIFO bank.
- It decodes the header address, sequences the packet load and parity states, and throttles the source via busy.
- New behaviour:
  - Selects fifo_full and fifo_empty internally from the latched destination.
  - Drives a one-hot destination select.
  - Discards packets whose address is out of range.

Parameters:
- NUM_PORTS, 3, number of destination FIFOs (2..16).
- ADDR_W, 2, header address width; 2**ADDR_W >= NUM_PORTS is required.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pkt_valid  in  1  source has a valid byte.
- din  in  ADDR_W  header address field (din[ADDR_W-1:0] of the header byte).
- fifo_full  in  NUM_PORTS  per-FIFO full flags.
- fifo_empty  in  NUM_PORTS  per-FIFO empty flags.
- soft_rst  in  NUM_PORTS  per-FIFO timeout soft resets.
- parity_done  in  1  parity byte has been registered.
- low_pkt_valid  in  1  pkt_valid fell while the FIFO was full.
- wr_en_reg  out  1  write enable to the FIFO path.
- detect_addr, lfd_state, ld_state, laf_state, full_state  out  1 each  state decodes.
- rst_int_reg  out  1  reset internal parity registers.
- drop_state  out  1  discarding an invalid packet.
- busy  out  1  stall the source.
- dest_sel  out  NUM_PORTS  one-hot latched destination.
- pkt_count  out  16  packets routed (optional feature).
- drop_count  out  16  packets dropped (optional feature).

Behaviour:
- States (4-bit encoding):
  - DA=0 (DECODE_ADDRESS), LFD=1 (LOAD_FIRST_DATA), LD=2 (LOAD_DATA), WTE=3 (WAIT_TILL_EMPTY)
  - CPE=4 (CHECK_PARITY_ERROR), LP=5 (LOAD_PARITY), FFS=6 (FIFO_FULL_STATE), LAF=7 (LOAD_AFTER_FULL), DROP=8
- Reset: on rst, go to DA and clear dest_q. Outputs after reset:
  - detect_addr=1
  - all other state decodes = 0, busy=0, dest_sel=0
  - counters = 0
- Destination latch: dest_q <= din on the edge where state==DA and pkt_valid==1. The address is valid iff din < NUM_PORTS.
- Muxed flags: full_sel = fifo_full[dest_q], empty_sel = fifo_empty[dest_q]. Flags of non-selected ports are ignored.
- DA transitions:
  - pkt_valid=1, valid address, fifo_empty[din]=1 -> LFD.
  - pkt_valid=1, valid address, fifo_empty[din]=0 -> WTE.
  - pkt_valid=1, invalid address -> DROP.
  - Otherwise stay in DA.
- WTE: empty_sel -> LFD, else stay.
- LFD: -> LD unconditionally.
- LD: full_sel -> FFS; else pkt_valid=0 -> LP; else stay.
- FFS: full_sel -> stay, else LAF.
- LAF:
  - parity_done -> DA.
  - Else low_pkt_valid -> LP.
  - Else LD.
- LP: -> CPE.
- CPE: full_sel -> FFS, else DA.
- DROP: pkt_valid=0 -> DA, else stay.
- Priority, highest first:
  1. rst
  2. soft_rst[dest_q] (in any state except DA and DROP) -> DA next cycle
  3. normal transitions
- soft_rst bits for non-selected ports are ignored. soft_rst is ignored in DA and DROP.
- Outputs are Moore (combinational from state only):
  - detect_addr = DA; lfd_state = LFD; ld_state = LD; laf_state = LAF; full_state = FFS; drop_state = DROP
  - wr_en_reg = LD | LP | LAF
  - rst_int_reg = CPE
  - busy = LFD | WTE | FFS | LAF | LP | CPE. busy is 0 in DA, LD and DROP, so the source streams discarded bytes.
  - dest_sel = one-hot(dest_q) in every state except DA and DROP, where it is 0.
- Latency: header accepted in DA -> lfd_state asserted the next cycle (empty FIFO), at most 1 cycle after empty_sel rises (WTE).
- Reset mid-packet: rst or soft_rst returns to DA with no further write enables. Partial packets are the FIFO's problem.

Optional Feature:
- Macro: ROUTER_STATS_EN
- Defined:
  - pkt_count increments on every LP->CPE transition.
  - drop_count increments on every DROP->DA transition.
  - Both saturate at 16'hFFFF and clear on rst only; soft_rst does not clear them.
- Undefined: both outputs are tied to 16'h0000 and no counter flops are synthesised. Ports exist in both builds.

Test Plan:
- rst=1 for 2 clks -> detect_addr=1, busy=0, dest_sel=0, wr_en_reg=0.
- din=2, pkt_valid=1, fifo_empty=3'b100 -> LFD with dest_sel=3'b100 and busy=1. Then LD with wr_en_reg=1. After pkt_valid=0: LP, then CPE (rst_int_reg=1), then DA. pkt_count=1 with ROUTER_STATS_EN.
- din=1, fifo_empty=3'b000 -> WTE with busy=1 for 3 clks. Raise fifo_empty[1] -> LFD next cycle.
- In LD with dest 0, set fifo_full=3'b010 -> stays in LD (non-selected port ignored). Set fifo_full=3'b001 -> FFS; clear it -> LAF. Then:
  - parity_done=0, low_pkt_valid=1 -> LP.
  - Repeat with parity_done=1 -> DA.
- NUM_PORTS=3, din=3, pkt_valid=1 for 5 clks -> DROP, drop_state=1, busy=0, wr_en_reg=0, dest_sel=0. Drop pkt_valid -> DA, drop_count=1.
- In WTE for dest 2, pulse soft_rst=3'b001 -> stays in WTE. Pulse soft_rst=3'b100 -> DA next cycle, busy=0. Assert rst during LD -> DA next cycle.

Source files
------------

// File: rtl/router_fsm_ctrl_n.sv
// Packet sequencing FSM for a 1xNUM_PORTS router: header decode, load/parity sequencing, source throttling.
// Optional macro ROUTER_STATS_EN adds saturating routed/dropped packet counters.
module router_fsm_ctrl_n #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    din,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_rst,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 wr_en_reg,
    output logic                 detect_addr,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 drop_state,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] dest_sel,
    output logic [15:0]          pkt_count,
    output logic [15:0]          drop_count
);

    typedef enum logic [3:0] {
        DA   = 4'd0,
        LFD  = 4'd1,
        LD   = 4'd2,
        WTE  = 4'd3,
        CPE  = 4'd4,
        LP   = 4'd5,
        FFS  = 4'd6,
        LAF  = 4'd7,
        DROP = 4'd8
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   dest_q, dest_nxt;
    logic [NUM_PORTS-1:0] dest_hit, din_hit, nxt_hit;
    logic                full_sel, empty_sel, soft_sel, empty_din, addr_ok;

    // Per-port match vectors replace variable indexing into the flag buses.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_match
        assign dest_hit[g] = (dest_q   == ADDR_W'(g));
        assign din_hit[g]  = (din      == ADDR_W'(g));
        assign nxt_hit[g]  = (dest_nxt == ADDR_W'(g));
    end

    assign full_sel  = |(fifo_full  & dest_hit);
    assign empty_sel = |(fifo_empty & dest_hit);
    assign soft_sel  = |(soft_rst   & dest_hit);
    assign empty_din = |(fifo_empty & din_hit);
    assign addr_ok   = |din_hit;

    // Next-state logic; a soft reset of the latched port aborts any in-flight packet.
    always_comb begin
        state_nxt = state;
        dest_nxt  = dest_q;
        if (state != DA && state != DROP && soft_sel) begin
            state_nxt = DA;
        end else begin
            case (state)
                DA: begin
                    if (pkt_valid) begin
                        dest_nxt = din;
                        if (!addr_ok)       state_nxt = DROP;
                        else if (empty_din) state_nxt = LFD;
                        else                state_nxt = WTE;
                    end
                end
                WTE:  if (empty_sel) state_nxt = LFD;
                LFD:  state_nxt = LD;
                LD: begin
                    if (full_sel)        state_nxt = FFS;
                    else if (!pkt_valid) state_nxt = LP;
                end
                FFS:  if (!full_sel) state_nxt = LAF;
                LAF: begin
                    if (parity_done)        state_nxt = DA;
                    else if (low_pkt_valid) state_nxt = LP;
                    else                    state_nxt = LD;
                end
                LP:   state_nxt = CPE;
                CPE:  state_nxt = full_sel ? FFS : DA;
                DROP: if (!pkt_valid) state_nxt = DA;
                default: state_nxt = DA;
            endcase
        end
    end

    // State register with outputs decoded from the next state, so they align with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DA;
            dest_q      <= '0;
            detect_addr <= 1'b1;
            lfd_state   <= 1'b0;
            ld_state    <= 1'b0;
            laf_state   <= 1'b0;
            full_state  <= 1'b0;
            drop_state  <= 1'b0;
            wr_en_reg   <= 1'b0;
            rst_int_reg <= 1'b0;
            busy        <= 1'b0;
            dest_sel    <= '0;
        end else begin
            state       <= state_nxt;
            dest_q      <= dest_nxt;
            detect_addr <= (state_nxt == DA);
            lfd_state   <= (state_nxt == LFD);
            ld_state    <= (state_nxt == LD);
            laf_state   <= (state_nxt == LAF);
            full_state  <= (state_nxt == FFS);
            drop_state  <= (state_nxt == DROP);
            wr_en_reg   <= (state_nxt == LD) || (state_nxt == LP) || (state_nxt == LAF);
            rst_int_reg <= (state_nxt == CPE);
            busy        <= (state_nxt == LFD) || (state_nxt == WTE) || (state_nxt == FFS) ||
                           (state_nxt == LAF) || (state_nxt == LP)  || (state_nxt == CPE);
            dest_sel    <= (state_nxt != DA && state_nxt != DROP) ? nxt_hit : '0;
        end
    end

`ifdef ROUTER_STATS_EN
    logic pkt_inc, drop_inc;

    assign pkt_inc  = (state == LP)   && (state_nxt == CPE);
    assign drop_inc = (state == DROP) && (state_nxt == DA);

    // Saturating statistics; only the hard reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count  <= 16'h0000;
            drop_count <= 16'h0000;
        end else begin
            if (pkt_inc && pkt_count != 16'hFFFF)   pkt_count  <= pkt_count + 16'd1;
            if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign pkt_count  = 16'h0000;
    assign drop_count = 16'h0000;
`endif

endmodule
